// File: rtl/width_upsizer.sv
// Packs RATIO narrow beats into one wide word. A word is emitted one cycle after its completing beat
// (the RATIO-th beat or a din_last flush). A held output stalls the input side.
module width_upsizer #(
  parameter int WIDTH_DIN = 8,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sclr,
  input  logic                         din_vld,
  output logic                         din_rdy,
  input  logic [WIDTH_DIN-1:0]         din,
  input  logic                         din_last,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic [RATIO*WIDTH_DIN-1:0]   dout,
  output logic [RATIO-1:0]             dout_keep,
  output logic                         dout_last
);

  localparam int OW = RATIO * WIDTH_DIN;
  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;

  logic [CW-1:0]    cnt_q, cnt_d, lane;
  logic [OW-1:0]    acc_q, acc_d, merged, dout_q, dout_d;
  logic [RATIO-1:0] keep_q, keep_d, keep_merged, dkeep_q, dkeep_d;
  logic             dlast_q, dlast_d, dvld_q, dvld_d;
  logic             accept, complete;

  assign din_rdy  = !dvld_q || dout_rdy;
  assign accept   = din_vld && din_rdy;
  assign complete = accept && ((cnt_q == CW'(RATIO - 1)) || din_last);
  assign lane     = (MSB_FIRST != 0) ? (CW'(RATIO - 1) - cnt_q) : cnt_q;

  // Current beat merged into the accumulator; used both to extend the partial word and to emit it.
  always_comb begin
    merged      = acc_q;
    keep_merged = keep_q;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CW'(i)) begin
        merged[i*WIDTH_DIN +: WIDTH_DIN] = din;
        keep_merged[i]                   = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    keep_d  = keep_q;
    dout_d  = dout_q;
    dkeep_d = dkeep_q;
    dlast_d = dlast_q;
    dvld_d  = dvld_q;
    if (sclr) begin
      cnt_d   = '0;
      acc_d   = '0;
      keep_d  = '0;
      dout_d  = '0;
      dkeep_d = '0;
      dlast_d = 1'b0;
      dvld_d  = 1'b0;
    end else if (complete) begin
      // A completing beat can only be accepted when the output slot is free or being consumed.
      dout_d  = merged;
      dkeep_d = keep_merged;
      dlast_d = din_last;
      dvld_d  = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
      keep_d  = '0;
    end else begin
      if (accept) begin
        acc_d  = merged;
        keep_d = keep_merged;
        cnt_d  = cnt_q + 1'b1;
      end
      if (dvld_q && dout_rdy) begin
        dvld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      keep_q  <= '0;
      dout_q  <= '0;
      dkeep_q <= '0;
      dlast_q <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      keep_q  <= keep_d;
      dout_q  <= dout_d;
      dkeep_q <= dkeep_d;
      dlast_q <= dlast_d;
      dvld_q  <= dvld_d;
    end
  end

  assign dout      = dout_q;
  assign dout_keep = dkeep_q;
  assign dout_last = dlast_q;
  assign dout_vld  = dvld_q;

endmodule
